fbank_lut_seq: RTL and testbench

FBANK_LUT_SEQ -- requirements
Module: fbank_lut_seq

---
 rtl/fbank_pkg.sv | 23 ++
 rtl/fbank_seq_skid.sv | 68 ++++++
 rtl/fbank_lut_seq.sv | 187 ++++++++++++++++++
 tb/tb_fbank_lut_seq.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fbank_pkg.sv
// fbank_pkg: shared definitions for the filter-bank LUT sequencer.
//   - Default LUT address/data widths.
//   - Sequencer FSM state encoding.
//   - Output beat record (coefficient data, bin index, last-bin flag).
package fbank_pkg;

    localparam int unsigned FBANK_ADDR_WIDTH = 10;
    localparam int unsigned FBANK_DATA_WIDTH = 17;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2,
        StHost  = 2'd3
    } fbank_state_e;

    typedef struct packed {
        logic [FBANK_DATA_WIDTH-1:0] data;
        logic [FBANK_ADDR_WIDTH-1:0] idx;
        logic                        last;
    } fbank_beat_t;

endpackage

// File: rtl/fbank_seq_skid.sv
// fbank_seq_skid: 2-entry output FIFO between the LUT read pipe and the coefficient stream.
// Ports:
//   clk, rst          single clock, synchronous active-high reset (empties the buffer)
//   push_i            write push_beat_i this cycle (caller guarantees a free slot)
//   push_beat_i       beat captured from the LUT read
//   out_valid_o       head entry present
//   out_ready_i       downstream accepts the head entry
//   out_beat_o        head entry, zero while empty
//   cnt_o             occupied entries (0..2)
module fbank_seq_skid
    import fbank_pkg::*;
#(
    parameter type beat_t = fbank_beat_t
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  beat_t      push_beat_i,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output beat_t      out_beat_o,
    output logic [1:0] cnt_o
);

    beat_t      ent_q [2];
    logic       rd_ptr_q, rd_ptr_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic [1:0] cnt_q, cnt_d;
    logic       pop;

    assign pop = (cnt_q != 2'd0) && out_ready_i;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        if (push_i) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        cnt_d = cnt_q + {1'b0, push_i} - {1'b0, pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ent_q[0] <= '0;
            ent_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            // A push into a full buffer only happens alongside a pop, so the slot
            // being overwritten is the one leaving this cycle.
            if (push_i) begin
                ent_q[wr_ptr_q] <= push_beat_i;
            end
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign out_valid_o = (cnt_q != 2'd0);
    assign out_beat_o  = out_valid_o ? ent_q[rd_ptr_q] : '0;
    assign cnt_o       = cnt_q;

endmodule

// File: rtl/fbank_lut_seq.sv
// fbank_lut_seq: streams BIN_CNT filter-bank coefficients out of a single-port LUT per frame
// pass and arbitrates host read/write access to the same LUT between passes.
// Ports:
//   clk, rst                        single clock, synchronous active-high reset
//   start / busy / done             pass request, pass active, one-cycle end-of-pass pulse
//   coef_valid/ready/data/idx/last  coefficient stream (valid/ready handshake)
//   host_req/we/addr/wdata          host access request, held until host_gnt
//   host_gnt/rdata/rvalid           one-cycle grant; read data the cycle after grant
//   lut_addr/wr_en/wr_data          LUT control; lut_rd_data valid one cycle after lut_addr
//   perf_stall_cnt                  stall-cycle counter, present only with FBANK_SEQ_PERF_EN
// Build option: define FBANK_SEQ_PERF_EN to add the saturating stall counter.
module fbank_lut_seq
    import fbank_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = FBANK_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = FBANK_DATA_WIDTH,
    parameter int unsigned BIN_CNT    = 512
) (
`ifdef FBANK_SEQ_PERF_EN
    output logic [15:0]           perf_stall_cnt,
`endif
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  coef_valid,
    input  logic                  coef_ready,
    output logic [DATA_WIDTH-1:0] coef_data,
    output logic [ADDR_WIDTH-1:0] coef_idx,
    output logic                  coef_last,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic                  host_gnt,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic                  host_rvalid,
    output logic [ADDR_WIDTH-1:0] lut_addr,
    output logic                  lut_wr_en,
    output logic [DATA_WIDTH-1:0] lut_wr_data,
    input  logic [DATA_WIDTH-1:0] lut_rd_data
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [ADDR_WIDTH-1:0] idx;
        logic                  last;
    } beat_t;

    localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(BIN_CNT - 1);

    fbank_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  pend_q;
    logic [ADDR_WIDTH-1:0] pend_idx_q;
    logic                  host_rvalid_q, host_rvalid_d;
    logic                  issue;
    logic                  accept;
    logic [1:0]            buf_cnt;
    logic [1:0]            free_slots;
    beat_t                 push_beat;
    beat_t                 out_beat;

    assign accept = coef_valid && coef_ready;

    // Slots free at the end of this cycle, counting a pop happening now; a read issued
    // now lands one cycle after the read already in flight, so it needs a slot beyond it.
    assign free_slots = 2'd2 - buf_cnt + {1'b0, accept};
    assign issue      = (state_q == StRun) && (free_slots > {1'b0, pend_q});

    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StRun;
                    rd_addr_d = '0;
                end else if (host_req) begin
                    state_d = StHost;
                end
            end
            StRun: begin
                if (issue) begin
                    rd_addr_d = rd_addr_q + 1'b1;
                    if (rd_addr_q == LastAddr) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (accept && coef_last) begin
                    state_d = StIdle;
                end
            end
            StHost:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign host_rvalid_d = (state_q == StHost) && !host_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            rd_addr_q     <= '0;
            pend_q        <= 1'b0;
            pend_idx_q    <= '0;
            host_rvalid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rd_addr_q     <= rd_addr_d;
            pend_q        <= issue;
            host_rvalid_q <= host_rvalid_d;
            if (issue) begin
                pend_idx_q <= rd_addr_q;
            end
        end
    end

    // LUT port: sequencer reads in RUN, host owns the port for its single grant cycle.
    always_comb begin
        lut_addr    = '0;
        lut_wr_en   = 1'b0;
        lut_wr_data = '0;
        if (state_q == StRun) begin
            lut_addr = rd_addr_q;
        end else if (state_q == StHost) begin
            lut_addr  = host_addr;
            lut_wr_en = host_we;
            if (host_we) begin
                lut_wr_data = host_wdata;
            end
        end
    end

    assign push_beat.data = lut_rd_data;
    assign push_beat.idx  = pend_idx_q;
    assign push_beat.last = (pend_idx_q == LastAddr);

    fbank_seq_skid #(
        .beat_t (beat_t)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .push_i      (pend_q),
        .push_beat_i (push_beat),
        .out_valid_o (coef_valid),
        .out_ready_i (coef_ready),
        .out_beat_o  (out_beat),
        .cnt_o       (buf_cnt)
    );

    assign coef_data   = out_beat.data;
    assign coef_idx    = out_beat.idx;
    assign coef_last   = out_beat.last;
    assign busy        = (state_q == StRun) || (state_q == StDrain);
    assign done        = (state_q == StDrain) && accept && coef_last;
    assign host_gnt    = (state_q == StHost);
    assign host_rvalid = host_rvalid_q;
    assign host_rdata  = host_rvalid_q ? lut_rd_data : '0;

`ifdef FBANK_SEQ_PERF_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == StIdle) && start) begin
            stall_cnt_d = '0;
        end else if (coef_valid && !coef_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fbank_lut_seq.sv
// Self-checking bench for fbank_lut_seq: a 512-bin instance with a RAM model and host traffic,
// plus a 1-bin instance fed by a fixed-content LUT.
module tb_fbank_lut_seq;

    localparam int AW   = 10;
    localparam int DW   = 17;
    localparam int BINS = 512;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, coef_ready, host_req, host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          busy, done, coef_valid, coef_last, host_gnt, host_rvalid, lut_wr_en;
    logic [DW-1:0] coef_data, host_rdata, lut_wr_data, lut_rd_data;
    logic [AW-1:0] coef_idx, lut_addr, lut_addr_q;

    logic          b_start, b_ready, b_busy, b_done, b_valid, b_last, b_gnt, b_rvalid, b_wr_en;
    logic [DW-1:0] b_data, b_rdata, b_wr_data, b_rd_data;
    logic [AW-1:0] b_idx, b_addr, b_addr_q;

`ifdef FBANK_SEQ_PERF_EN
    logic [15:0] perf_stall_cnt, b_perf;
`endif

    logic [DW-1:0] lut_mem [2**AW];
    logic [DW-1:0] ref_mem [2**AW];
    int vectors = 0;
    int miscompares = 0;

    fbank_lut_seq #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BIN_CNT(BINS)) u_dut (
`ifdef FBANK_SEQ_PERF_EN
        .perf_stall_cnt (perf_stall_cnt),
`endif
        .clk (clk), .rst (rst), .start (start), .busy (busy), .done (done),
        .coef_valid (coef_valid), .coef_ready (coef_ready), .coef_data (coef_data),
        .coef_idx (coef_idx), .coef_last (coef_last),
        .host_req (host_req), .host_we (host_we), .host_addr (host_addr),
        .host_wdata (host_wdata), .host_gnt (host_gnt), .host_rdata (host_rdata),
        .host_rvalid (host_rvalid), .lut_addr (lut_addr), .lut_wr_en (lut_wr_en),
        .lut_wr_data (lut_wr_data), .lut_rd_data (lut_rd_data)
    );

    fbank_lut_seq #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BIN_CNT(1)) u_dut_b (
`ifdef FBANK_SEQ_PERF_EN
        .perf_stall_cnt (b_perf),
`endif
        .clk (clk), .rst (rst), .start (b_start), .busy (b_busy), .done (b_done),
        .coef_valid (b_valid), .coef_ready (b_ready), .coef_data (b_data),
        .coef_idx (b_idx), .coef_last (b_last),
        .host_req (1'b0), .host_we (1'b0), .host_addr ('0),
        .host_wdata ('0), .host_gnt (b_gnt), .host_rdata (b_rdata),
        .host_rvalid (b_rvalid), .lut_addr (b_addr), .lut_wr_en (b_wr_en),
        .lut_wr_data (b_wr_data), .lut_rd_data (b_rd_data)
    );

    // Single-port RAM models: address registered at the clock edge, data out combinationally.
    initial begin
        logic [AW-1:0] a, ab;
        logic          we;
        logic [DW-1:0] wd;
        for (int i = 0; i < 2**AW; i++) lut_mem[i] = DW'(32'h1000 + i);
        lut_addr_q = '0;
        b_addr_q   = '0;
        forever begin
            @(posedge clk);
            a  = lut_addr;
            ab = b_addr;
            we = lut_wr_en;
            wd = lut_wr_data;
            #1;
            if (we) lut_mem[a] = wd;
            lut_addr_q = a;
            b_addr_q   = ab;
        end
    end
    assign lut_rd_data = lut_mem[lut_addr_q];
    assign b_rd_data   = DW'(32'h1000 + 32'(b_addr_q));

    // Returns 1 time unit after the rising edge; callers change inputs, then wait #1 to check.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        #1;
        vectors++;
        if ({busy, done, coef_valid, coef_last, host_gnt, host_rvalid, lut_wr_en, coef_data,
             coef_idx, host_rdata, lut_addr, lut_wr_data} !== '0) begin
            miscompares++;
            $display("FAIL reset_a busy=%b done=%b valid=%b data=%h idx=%h addr=%h required all 0",
                     busy, done, coef_valid, coef_data, coef_idx, lut_addr);
        end
        vectors++;
        if ({b_busy, b_done, b_valid, b_last, b_gnt, b_rvalid, b_wr_en, b_data, b_idx, b_rdata,
             b_addr, b_wr_data} !== '0) begin
            miscompares++;
            $display("FAIL reset_b busy=%b valid=%b data=%h idx=%h required all 0",
                     b_busy, b_valid, b_data, b_idx);
        end
        rst = 1'b0;
        next_cycle();
        #1;
        vectors++;
        if ({busy, coef_valid, host_gnt, lut_wr_en, lut_addr} !== '0) begin
            miscompares++;
            $display("FAIL idle_after_reset busy=%b valid=%b gnt=%b addr=%h required all 0",
                     busy, coef_valid, host_gnt, lut_addr);
        end
    endtask

    task automatic test_full_pass();
        int k = 0;
        int cyc = 0;
        int gaps = 0;
        start      = 1'b1;
        coef_ready = 1'b1;
        next_cycle();
        start = 1'b0;
        #1;
        vectors++;
        if (coef_valid !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL pass_cycle1 valid=%b busy=%b required valid=0 busy=1", coef_valid, busy);
        end
        next_cycle();
        #1;
        vectors++;
        if (coef_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL pass_cycle2 valid=%b required 0", coef_valid);
        end
        next_cycle();
        #1;
        vectors++;
        if (coef_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL pass_first_valid valid=%b required 1 at start+2", coef_valid);
        end
        while (k < BINS && cyc < 2000) begin
            if (coef_valid === 1'b1) begin
                vectors++;
                if (coef_idx !== AW'(k) || coef_data !== ref_mem[k] ||
                    coef_last !== (k == BINS - 1) || done !== (k == BINS - 1)) begin
                    miscompares++;
                    $display("FAIL pass_beat k=%0d idx=%h data=%h last=%b done=%b required %h/%h",
                             k, coef_idx, coef_data, coef_last, done, AW'(k), ref_mem[k]);
                end
                k++;
            end else begin
                gaps++;
            end
            cyc++;
            next_cycle();
            #1;
        end
        vectors++;
        if (k != BINS || gaps != 0) begin
            miscompares++;
            $display("FAIL pass_count beats=%0d gaps=%0d required beats=%0d gaps=0", k, gaps, BINS);
        end
        vectors++;
        if (busy !== 1'b0 || coef_valid !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL pass_end busy=%b valid=%b done=%b required 0", busy, coef_valid, done);
        end
    endtask

    task automatic test_random_ready(input string tag);
        int k = 0;
        int cyc = 0;
        int stalls = 0;
        logic          prev_stall = 1'b0;
        logic [DW-1:0] prev_data = '0;
        logic [AW-1:0] prev_idx = '0;
        logic          prev_last = 1'b0;
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        while (k < BINS && cyc < 6000) begin
            coef_ready = 1'($urandom_range(0, 1));
            #1;
            if (prev_stall) begin
                vectors++;
                if (coef_valid !== 1'b1 || coef_data !== prev_data || coef_idx !== prev_idx ||
                    coef_last !== prev_last) begin
                    miscompares++;
                    $display("FAIL %s_stable valid=%b data=%h idx=%h required data=%h idx=%h",
                             tag, coef_valid, coef_data, coef_idx, prev_data, prev_idx);
                end
            end
            if (coef_valid === 1'b1) begin
                vectors++;
                if (coef_idx !== AW'(k) || coef_data !== ref_mem[k] ||
                    coef_last !== (k == BINS - 1)) begin
                    miscompares++;
                    $display("FAIL %s_beat k=%0d idx=%h data=%h last=%b required %h/%h",
                             tag, k, coef_idx, coef_data, coef_last, AW'(k), ref_mem[k]);
                end
                if (coef_ready) begin
                    vectors++;
                    if (done !== (k == BINS - 1)) begin
                        miscompares++;
                        $display("FAIL %s_done k=%0d done=%b required %b",
                                 tag, k, done, (k == BINS - 1));
                    end
                    k++;
                end else begin
                    stalls++;
                end
            end
            prev_stall = coef_valid && !coef_ready;
            prev_data  = coef_data;
            prev_idx   = coef_idx;
            prev_last  = coef_last;
            cyc++;
            next_cycle();
        end
        #1;
        vectors++;
        if (k != BINS || busy !== 1'b0 || coef_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_end beats=%0d busy=%b valid=%b required beats=%0d busy=0 valid=0",
                     tag, k, busy, coef_valid, BINS);
        end
`ifdef FBANK_SEQ_PERF_EN
        vectors++;
        if (perf_stall_cnt !== 16'(stalls)) begin
            miscompares++;
            $display("FAIL %s_perf cnt=%0d required %0d", tag, perf_stall_cnt, stalls);
        end
`endif
    endtask

    task automatic test_start_host_collision();
        int k = 0;
        int cyc = 0;
        int gnt_early = 0;
        logic done_seen = 1'b0;
        start      = 1'b1;
        coef_ready = 1'b1;
        host_req   = 1'b1;
        host_we    = 1'b0;
        host_addr  = AW'(10'h005);
        next_cycle();
        start = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b1 || host_gnt !== 1'b0) begin
            miscompares++;
            $display("FAIL coll_start_wins busy=%b gnt=%b required busy=1 gnt=0", busy, host_gnt);
        end
        while (!done_seen && cyc < 2000) begin
            if (host_gnt !== 1'b0) gnt_early++;
            if (coef_valid === 1'b1 && coef_ready) k++;
            if (done === 1'b1) done_seen = 1'b1;
            cyc++;
            next_cycle();
            #1;
        end
        vectors++;
        if (!done_seen || k != BINS || gnt_early != 0) begin
            miscompares++;
            $display("FAIL coll_pass done=%b beats=%0d early_gnt=%0d required 1/%0d/0",
                     done_seen, k, gnt_early, BINS);
        end
        for (int i = 0; i < 4 && host_gnt !== 1'b1; i++) begin
            next_cycle();
            #1;
        end
        vectors++;
        if (host_gnt !== 1'b1 || lut_addr !== AW'(10'h005) || lut_wr_en !== 1'b0) begin
            miscompares++;
            $display("FAIL coll_gnt gnt=%b addr=%h we=%b required 1/005/0",
                     host_gnt, lut_addr, lut_wr_en);
        end
        host_req = 1'b0;
        next_cycle();
        #1;
        vectors++;
        if (host_rvalid !== 1'b1 || host_rdata !== ref_mem[5] || host_gnt !== 1'b0) begin
            miscompares++;
            $display("FAIL coll_rdata rvalid=%b rdata=%h gnt=%b required 1/%h/0",
                     host_rvalid, host_rdata, host_gnt, ref_mem[5]);
        end
    endtask

    task automatic test_host_write_read();
        host_req   = 1'b1;
        host_we    = 1'b1;
        host_addr  = AW'(10'h3FF);
        host_wdata = DW'(17'h1ABCD);
        for (int i = 0; i < 4 && host_gnt !== 1'b1; i++) begin
            next_cycle();
            #1;
        end
        vectors++;
        if (host_gnt !== 1'b1 || lut_wr_en !== 1'b1 || lut_addr !== AW'(10'h3FF) ||
            lut_wr_data !== DW'(17'h1ABCD)) begin
            miscompares++;
            $display("FAIL hw_grant gnt=%b we=%b addr=%h wdata=%h required 1/1/3ff/1abcd",
                     host_gnt, lut_wr_en, lut_addr, lut_wr_data);
        end
        ref_mem[10'h3FF] = DW'(17'h1ABCD);
        host_req = 1'b0;
        next_cycle();
        #1;
        vectors++;
        if (lut_wr_en !== 1'b0 || host_rvalid !== 1'b0 || host_gnt !== 1'b0) begin
            miscompares++;
            $display("FAIL hw_after we=%b rvalid=%b gnt=%b required 0/0/0",
                     lut_wr_en, host_rvalid, host_gnt);
        end
        host_req = 1'b1;
        host_we  = 1'b0;
        for (int i = 0; i < 4 && host_gnt !== 1'b1; i++) begin
            next_cycle();
            #1;
        end
        vectors++;
        if (host_gnt !== 1'b1 || lut_wr_en !== 1'b0) begin
            miscompares++;
            $display("FAIL hr_grant gnt=%b we=%b required 1/0", host_gnt, lut_wr_en);
        end
        host_req = 1'b0;
        next_cycle();
        #1;
        vectors++;
        if (host_rvalid !== 1'b1 || host_rdata !== ref_mem[10'h3FF]) begin
            miscompares++;
            $display("FAIL hr_rdata rvalid=%b rdata=%h required 1/%h",
                     host_rvalid, host_rdata, ref_mem[10'h3FF]);
        end
    endtask

    task automatic test_reset_mid_pass();
        int cyc = 0;
        int bad = 0;
        start      = 1'b1;
        coef_ready = 1'b1;
        next_cycle();
        start = 1'b0;
        #1;
        while (!(coef_valid === 1'b1 && coef_idx === AW'(100)) && cyc < 300) begin
            cyc++;
            next_cycle();
            #1;
        end
        vectors++;
        if (coef_valid !== 1'b1 || coef_idx !== AW'(100)) begin
            miscompares++;
            $display("FAIL rst_reach_100 valid=%b idx=%h required 1/064", coef_valid, coef_idx);
        end
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        #1;
        vectors++;
        if ({busy, done, coef_valid, coef_last, host_gnt, host_rvalid, lut_wr_en, coef_data,
             coef_idx, host_rdata, lut_addr, lut_wr_data} !== '0) begin
            miscompares++;
            $display("FAIL rst_mid_outputs busy=%b valid=%b data=%h idx=%h addr=%h required 0",
                     busy, coef_valid, coef_data, coef_idx, lut_addr);
        end
        for (int i = 0; i < 10; i++) begin
            if (done !== 1'b0 || coef_valid !== 1'b0 || busy !== 1'b0) bad++;
            next_cycle();
            #1;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL rst_mid_quiet bad_cycles=%0d required 0", bad);
        end
    endtask

    task automatic test_bin1();
        int bad = 0;
        b_start = 1'b1;
        next_cycle();
        #1;
        vectors++;
        if (b_busy !== 1'b1 || b_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bin1_busy busy=%b valid=%b required 1/0", b_busy, b_valid);
        end
        // start still high across this edge while busy: must be ignored
        next_cycle();
        b_start = 1'b0;
        #1;
        vectors++;
        if (b_valid !== 1'b0 || b_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL bin1_cycle2 valid=%b busy=%b required 0/1", b_valid, b_busy);
        end
        next_cycle();
        #1;
        vectors++;
        if (b_valid !== 1'b1 || b_idx !== '0 || b_last !== 1'b1 || b_done !== 1'b1 ||
            b_data !== DW'(17'h1000)) begin
            miscompares++;
            $display("FAIL bin1_beat valid=%b idx=%h last=%b done=%b data=%h required 1/0/1/1/1000",
                     b_valid, b_idx, b_last, b_done, b_data);
        end
        for (int i = 0; i < 8; i++) begin
            next_cycle();
            #1;
            if (b_valid !== 1'b0 || b_busy !== 1'b0 || b_done !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL bin1_second_start_ignored bad_cycles=%0d required 0", bad);
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        coef_ready = 1'b0;
        host_req   = 1'b0;
        host_we    = 1'b0;
        host_addr  = '0;
        host_wdata = '0;
        b_start    = 1'b0;
        b_ready    = 1'b1;
        for (int i = 0; i < 2**AW; i++) ref_mem[i] = DW'(32'h1000 + i);
        test_reset();
        test_full_pass();
        test_random_ready("rand");
        test_start_host_collision();
        test_host_write_read();
        test_reset_mid_pass();
        test_random_ready("after_rst");
        test_bin1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
